// File: rtl/checkpoint_queue.sv
// Branch-checkpoint ring buffer for rename: allocates snapshots in program order,
// retires validated ones from the oldest end, and restores and squashes on recall.
module checkpoint_queue #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 512,
  parameter int ALLOC_W  = 2,
  parameter int RES_W    = 2,
  parameter int RETIRE_W = 2,
  localparam int IDW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ext_stall,
  input  logic                   ext_flush,
  input  logic [ALLOC_W-1:0]     alloc_req,
  input  logic [ALLOC_W*WIDTH-1:0] alloc_data,
  output logic                   alloc_ready,
  output logic [ALLOC_W*IDW-1:0] alloc_id,
  input  logic [RES_W-1:0]       validate,
  input  logic [RES_W*IDW-1:0]   validated_id,
  input  logic                   recall,
  input  logic [IDW-1:0]         recall_id,
  output logic [WIDTH-1:0]       recall_data,
  output logic                   recall_valid,
  output logic                   recall_err,
  output logic [IDW:0]           count,
  output logic                   full,
  output logic                   empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] done_q, done_d;
  logic [IDW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [IDW:0]     count_q, count_d;
  logic [WIDTH-1:0] recall_data_q;
  logic             recall_valid_q, recall_err_q;

  logic [IDW:0]     prefix [ALLOC_W+1];
  logic [IDW-1:0]   slot_id [ALLOC_W];
  logic [IDW-1:0]   val_id [RES_W];
  logic [IDW-1:0]   val_off [RES_W];
  logic [IDW:0]     pop;
  logic             accept;
  logic [IDW-1:0]   rc_off;
  logic             rc_live, rc_take;
  logic [IDW:0]     ret_n;
  logic             ret_run;

  // Slot k gets tail plus the number of requesting slots below it.
  assign prefix[0] = '0;
  generate
    for (genvar gi = 0; gi < ALLOC_W; gi++) begin : g_slot
      assign prefix[gi+1] = prefix[gi] + (IDW+1)'(alloc_req[gi]);
      assign slot_id[gi]  = tail_q + prefix[gi][IDW-1:0];
      assign alloc_id[gi*IDW +: IDW] = slot_id[gi];
    end
    for (genvar gi = 0; gi < RES_W; gi++) begin : g_val
      assign val_id[gi]  = validated_id[gi*IDW +: IDW];
      assign val_off[gi] = val_id[gi] - head_q;
    end
  endgenerate

  assign pop         = prefix[ALLOC_W];
  assign alloc_ready = ~ext_stall & ~ext_flush & ~recall &
                       (({1'b0, count_q} + {1'b0, pop}) <= (IDW+2)'(DEPTH));
  assign accept      = alloc_ready & (|alloc_req);

  assign rc_off  = recall_id - head_q;
  assign rc_live = {1'b0, rc_off} < count_q;
  assign rc_take = recall & rc_live & ~ext_flush;

  always_comb begin
    ret_n   = '0;
    ret_run = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (ret_run && ((IDW+1)'(i) < count_q) && done_q[head_q + IDW'(i)])
        ret_n = ret_n + (IDW+1)'(1);
      else
        ret_run = 1'b0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    // Validates only land on entries that are live now and survive any recall.
    for (int r = 0; r < RES_W; r++) begin
      if (validate[r] && ({1'b0, val_off[r]} < count_q) &&
          !(rc_take && (val_off[r] >= rc_off)))
        done_d[val_id[r]] = 1'b1;
    end
    if (ext_flush) begin
      head_d  = tail_q;
      count_d = '0;
      done_d  = '0;
    end else if (recall) begin
      if (rc_live) begin
        tail_d  = recall_id;
        count_d = {1'b0, rc_off};
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < ALLOC_W; k++)
          if (alloc_req[k]) done_d[slot_id[k]] = 1'b0;
        tail_d = tail_q + pop[IDW-1:0];
      end
      head_d  = head_q + ret_n[IDW-1:0];
      count_d = count_q + (accept ? pop : '0) - ret_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      done_q         <= '0;
      recall_data_q  <= '0;
      recall_valid_q <= 1'b0;
      recall_err_q   <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      done_q         <= done_d;
      recall_valid_q <= rc_take;
      recall_err_q   <= recall & ~rc_live & ~ext_flush;
      if (rc_take) recall_data_q <= mem[recall_id];
    end
  end

  // Payload store; recall and allocation never share a cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ALLOC_W; k++)
      if (accept && alloc_req[k]) mem[slot_id[k]] <= alloc_data[k*WIDTH +: WIDTH];
  end

  assign recall_data  = recall_data_q;
  assign recall_valid = recall_valid_q;
  assign recall_err   = recall_err_q;
  assign count        = count_q;
  assign full         = (count_q == (IDW+1)'(DEPTH));
  assign empty        = (count_q == '0);

endmodule
